param_shift_reg: RTL

Parametrised multi-mode register. It generalises the single-bit D flip-flop into a WIDTH-bit register with clock enable, asynchronous reset, parallel load, left/right shift and rotate, plus a shift counter that reports when a full word has been shifted through. It is used as the serial/parallel conversion and storage primitive for later blocks in the series.

---
 rtl/param_shift_reg.sv | 124 ++++++++++++
 1 files changed

// File: rtl/param_shift_reg.sv
// -----------------------------------------------------------------------------
// param_shift_reg
//   WIDTH-bit multi-mode register: hold, shift left, shift right, parallel
//   load, with optional rotate. A saturating shift counter reports how many
//   shifts have happened since the last load or reset. A one-cycle done pulse
//   is raised in the cycle after the WIDTH-th shift.
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (q=RESET_VAL, cnt=0, done=0)
//   en     : clock enable; low holds q and cnt and clears done
//   mode   : 00 hold, 01 shift left, 10 shift right, 11 parallel load
//   rot    : 1 turns shifts into rotates (sin ignored)
//   sin    : serial input bit for shifts
//   d      : parallel load data
//   q      : register contents
//   sout_l : q[WIDTH-1]
//   sout_r : q[0]
//   cnt    : shifts since last load/reset, saturating at WIDTH
//   done   : one-cycle pulse when cnt reaches WIDTH
// -----------------------------------------------------------------------------
module param_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic             fill_l;
  logic             fill_r;

  // Bit entering at the vacated end: the bit falling off the other end when
  // rotating, otherwise the serial input.
  assign fill_l = rot ? q_reg[WIDTH-1] : sin;
  assign fill_r = rot ? q_reg[0]       : sin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign shl_val[gi] = fill_l;
      end else begin : g_not_lsb
        assign shl_val[gi] = q_reg[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_val[gi] = fill_r;
      end else begin : g_not_msb
        assign shr_val[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    q_next    = q_reg;
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHL, MODE_SHR: begin
          q_next = (mode == MODE_SHL) ? shl_val : shr_val;
          // Saturate rather than wrap so done cannot re-fire without a load.
          if (cnt_reg != CNT_FULL) begin
            cnt_next = cnt_reg + CW'(1);
          end
          done_next = (cnt_reg == CNT_LAST);
        end
        MODE_LOAD: begin
          q_next   = d;
          cnt_next = '0;
        end
        MODE_HOLD: begin
          q_next = q_reg;
        end
        default: begin
          q_next = q_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg    <= RESET_VAL;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign q      = q_reg;
  assign cnt    = cnt_reg;
  assign done   = done_reg;
  assign sout_l = q_reg[WIDTH-1];
  assign sout_r = q_reg[0];

endmodule
